// File: rtl/fsmd_gray_decoder.sv
// Bit-serial Gray-to-binary decoder with valid/ready ports,
// adjacency checking of consecutive words and overrun detection.
module fsmd_gray_decoder #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] bin_out,
    output logic             adj_err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] err_cnt,
    output logic             overrun,
    input  logic             seq_clr
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [IW-1:0] IDX_MAX = IW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] g_q, g_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] prev_gray_q, prev_gray_d;
    logic             prev_valid_q, prev_valid_d;
    logic             adj_q, adj_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovr_q, ovr_d;

    logic [WIDTH-1:0] diff;
    logic [IW-1:0]    idx_up;
    logic             one_hot;
    logic             accept;

    always_comb begin
        state_d      = state_q;
        g_d          = g_q;
        b_d          = b_q;
        idx_d        = idx_q;
        prev_gray_d  = prev_gray_q;
        prev_valid_d = prev_valid_q;
        adj_d        = adj_q;
        cnt_d        = cnt_q;
        ovr_d        = ovr_q;

        diff    = gray_in ^ prev_gray_q;
        one_hot = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);
        idx_up  = idx_q + IW'(1);
        accept  = (state_q == S_IDLE) && in_valid;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    g_d     = gray_in;
                    idx_d   = IDX_MAX;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // MSB copies through; lower bits fold in the bit just above
                if (idx_q == IDX_MAX)
                    b_d[idx_q] = g_q[idx_q];
                else
                    b_d[idx_q] = b_q[idx_up] ^ g_q[idx_q];
                if (idx_q == '0) begin
                    idx_d   = IDX_MAX;
                    state_d = S_HOLD;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            S_HOLD: begin
                if (out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            prev_gray_d  = gray_in;
            prev_valid_d = 1'b1;
            if (prev_valid_q && !one_hot && !seq_clr) begin
                adj_d = 1'b1;
                if (cnt_q != '1)
                    cnt_d = cnt_q + CNT_W'(1);
            end else begin
                adj_d = 1'b0;
            end
        end

        if (in_valid && (state_q != S_IDLE))
            ovr_d = 1'b1;

        // A clear coinciding with an accept still seeds the new history
        if (seq_clr) begin
            cnt_d = '0;
            ovr_d = 1'b0;
            if (!accept)
                prev_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            g_q          <= '0;
            b_q          <= '0;
            idx_q        <= IDX_MAX;
            prev_gray_q  <= '0;
            prev_valid_q <= 1'b0;
            adj_q        <= 1'b0;
            cnt_q        <= '0;
            ovr_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            g_q          <= g_d;
            b_q          <= b_d;
            idx_q        <= idx_d;
            prev_gray_q  <= prev_gray_d;
            prev_valid_q <= prev_valid_d;
            adj_q        <= adj_d;
            cnt_q        <= cnt_d;
            ovr_q        <= ovr_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_HOLD);
    assign bin_out   = b_q;
    assign adj_err   = adj_q;
    assign err_cnt   = cnt_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_fsmd_gray_decoder.sv
// Directed vector bench for fsmd_gray_decoder (WIDTH=4, CNT_W=2
// so counter saturation is reachable with few words).
module tb_fsmd_gray_decoder;

    localparam int W = 4;
    localparam int C = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] gray_in;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] bin_out;
    logic         adj_err;
    logic         out_valid;
    logic         out_ready;
    logic [C-1:0] err_cnt;
    logic         overrun;
    logic         seq_clr;

    int nvec = 0;
    int nmis = 0;

    fsmd_gray_decoder #(.WIDTH(W), .CNT_W(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .gray_in   (gray_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin_out   (bin_out),
        .adj_err   (adj_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_cnt   (err_cnt),
        .overrun   (overrun),
        .seq_clr   (seq_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] gray;
        logic         clr;
        logic [W-1:0] bin;
        logic         adj;
        logic [C-1:0] cnt;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send(input logic [W-1:0] g, input logic clr);
        for (int i = 0; i < 20 && !in_ready; i++) begin
            @(posedge clk);
            #1;
        end
        check("in_ready_before_send", int'(in_ready), 1);
        gray_in  = g;
        in_valid = 1'b1;
        seq_clr  = clr;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        seq_clr  = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid)
            check("out_valid_timeout", 0, 1);
    endtask

    task automatic pulse_clr();
        seq_clr = 1'b1;
        @(posedge clk);
        #1;
        seq_clr = 1'b0;
    endtask

    initial begin
        int lat;
        logic [W-1:0] held;

        vecs[0]  = '{4'b0110, 1'b0, 4'b0100, 1'b0, 2'd0};
        vecs[1]  = '{4'b1000, 1'b1, 4'b1111, 1'b0, 2'd0};
        vecs[2]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
        vecs[3]  = '{4'b0001, 1'b0, 4'b0001, 1'b0, 2'd0};
        vecs[4]  = '{4'b0111, 1'b0, 4'b0101, 1'b1, 2'd1};
        vecs[5]  = '{4'b0111, 1'b0, 4'b0101, 1'b1, 2'd2};
        vecs[6]  = '{4'b0101, 1'b0, 4'b0110, 1'b0, 2'd2};
        vecs[7]  = '{4'b1101, 1'b0, 4'b1001, 1'b0, 2'd2};
        vecs[8]  = '{4'b1111, 1'b0, 4'b1010, 1'b0, 2'd2};
        vecs[9]  = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd3};
        vecs[10] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
        vecs[11] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd1};
        vecs[12] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2};
        vecs[13] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd3};
        vecs[14] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd3};
        vecs[15] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd3};
        vecs[16] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};

        rst       = 1'b1;
        gray_in   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        seq_clr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_bin", int'(bin_out), 0);
        check("rst_adj", int'(adj_err), 0);
        check("rst_cnt", int'(err_cnt), 0);
        check("rst_overrun", int'(overrun), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 17; i++) begin
            send(vecs[i].gray, vecs[i].clr);
            wait_out(lat);
            check($sformatf("v%0d_latency", i), lat, W);
            check($sformatf("v%0d_bin", i), int'(bin_out), int'(vecs[i].bin));
            check($sformatf("v%0d_adj", i), int'(adj_err), int'(vecs[i].adj));
            check($sformatf("v%0d_cnt", i), int'(err_cnt), int'(vecs[i].cnt));
        end

        // backpressure: HOLD must persist with stable data
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(4'b0011, 1'b0);
        wait_out(lat);
        check("bp_latency", lat, W);
        check("bp_bin", int'(bin_out), 4'b0010);
        held = bin_out;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_bin_stable", int'(bin_out), int'(held));
            check("bp_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_idle_in_ready", int'(in_ready), 1);
        check("bp_idle_out_valid", int'(out_valid), 0);

        // overrun: dropped word must not become history
        pulse_clr();
        send(4'b0100, 1'b0);
        @(posedge clk);
        #1;
        gray_in  = 4'b1111;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("ovr_set", int'(overrun), 1);
        wait_out(lat);
        check("ovr_bin", int'(bin_out), 4'b0111);
        check("ovr_adj", int'(adj_err), 0);
        @(posedge clk);
        #1;
        send(4'b0111, 1'b0);
        wait_out(lat);
        check("ovr_next_bin", int'(bin_out), 4'b0101);
        check("ovr_next_adj", int'(adj_err), 1);
        check("ovr_next_cnt", int'(err_cnt), 1);
        check("ovr_sticky", int'(overrun), 1);
        @(posedge clk);
        #1;
        pulse_clr();
        check("clr_overrun", int'(overrun), 0);
        check("clr_cnt", int'(err_cnt), 0);

        // reset mid-SHIFT
        send(4'b0110, 1'b0);
        send(4'b0011, 1'b0);
        @(posedge clk);
        #1;
        check("pre_rst_in_shift", int'(in_ready), 0);
        check("pre_rst_cnt", int'(err_cnt), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", int'(in_ready), 1);
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_bin", int'(bin_out), 0);
        check("mid_rst_adj", int'(adj_err), 0);
        check("mid_rst_cnt", int'(err_cnt), 0);
        check("mid_rst_overrun", int'(overrun), 0);
        @(posedge clk);
        #1;
        check("hold_rst_out_valid", int'(out_valid), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(4'b0001, 1'b0);
        wait_out(lat);
        check("post_rst_latency", lat, W);
        check("post_rst_bin", int'(bin_out), 4'b0001);
        check("post_rst_adj", int'(adj_err), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
